// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares a single FIFO write port among num_req producers.
// Each grant covers a bounded burst; full stalls the burst without losing its place.
module fifo_wr_arbiter #(
  parameter int num_req    = 4,
  parameter int word_width = 8,
  parameter int max_burst  = 4
) (
  input  logic                          w_clk,
  input  logic                          reset_n,
  input  logic [num_req-1:0]            req,
  input  logic [num_req*word_width-1:0] req_data,
  input  logic [num_req-1:0]            req_last,
  input  logic                          full,
  output logic                          wr,
  output logic [word_width-1:0]         data_in,
  output logic [num_req-1:0]            grant,
  output logic [num_req-1:0]            ack,
  output logic                          busy
);

  // state   | meaning
  // st_idle | no grant; picks the next requester after the round-robin pointer
  // st_xfer | one producer granted; writes while req & ~full, leaves on last/burst/withdraw
  localparam int cnt_w = $clog2(max_burst) + 1;
  localparam int ptr_w = (num_req > 1) ? $clog2(num_req) : 1;

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_xfer = 1'b1;

  logic [0:0]       state;
  logic [cnt_w-1:0] count;
  logic [ptr_w-1:0] ptr;
  logic [ptr_w-1:0] sel_idx;
  logic [ptr_w-1:0] g_idx;
  logic             sel_found;
  logic             req_g;
  logic             last_g;
  logic             burst_end;
  logic             exit_xfer;

  // Search upward from ptr+1 so the last-served producer has lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 1; i <= num_req; i++) begin
      if (!sel_found && req[(int'(ptr) + i) % num_req]) begin
        sel_found = 1'b1;
        sel_idx   = ptr_w'((int'(ptr) + i) % num_req);
      end
    end
  end

  always_comb begin
    g_idx   = '0;
    req_g   = 1'b0;
    last_g  = 1'b0;
    data_in = '0;
    for (int i = 0; i < num_req; i++) begin
      if (grant[i]) begin
        g_idx   = ptr_w'(i);
        req_g   = req[i];
        last_g  = req_last[i];
        data_in = req_data[i*word_width +: word_width];
      end
    end
  end

  assign busy      = (state == st_xfer);
  assign wr        = busy & req_g & ~full;
  assign ack       = grant & {num_req{wr}};
  assign burst_end = (count == cnt_w'(max_burst - 1));
  // A withdrawn request ends the burst even while full is stalling it.
  assign exit_xfer = ~req_g | (wr & (last_g | burst_end));

  always_ff @(posedge w_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= st_idle;
      grant <= '0;
      count <= '0;
      ptr   <= ptr_w'(num_req - 1);
    end else begin
      case (state)
        st_idle: begin
          if (sel_found) begin
            grant <= num_req'(1) << sel_idx;
            count <= '0;
            state <= st_xfer;
          end
        end
        st_xfer: begin
          if (exit_xfer) begin
            ptr   <= g_idx;
            grant <= '0;
            count <= '0;
            state <= st_idle;
          end else if (wr) begin
            count <= count + cnt_w'(1);
          end
        end
        default: begin
          grant <= '0;
          count <= '0;
          state <= st_idle;
        end
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge w_clk) disable iff (!reset_n) $onehot0(grant));
  a_no_wr_full:   assert property (@(posedge w_clk) disable iff (!reset_n) full |-> !wr);
  a_ack_grant:    assert property (@(posedge w_clk) disable iff (!reset_n) wr |-> (ack == grant));
  a_count_bound:  assert property (@(posedge w_clk) disable iff (!reset_n)
                                   count <= cnt_w'(max_burst - 1));

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter for the async FIFO (asyn_fifo_top).
- Sits entirely in the w_clk domain.
- Shares the FIFO's single write port (wr, data_in, full) among NUM_REQ producers.
- Grants one producer at a time for a bounded burst.
- Stalls cleanly on full.
- Rotates priority so no producer starves.

Parameters:
- num_req, 4, number of requesting producers (2..8).
- word_width, 8, FIFO word width; must match the FIFO instance.
- max_burst, 4, max words one producer may write per grant (1..16).

Ports:
- w_clk  in  1  write-domain clock (same clock as FIFO w_clk). This is the block's one clock.
- reset_n  in  1  asynchronous active-low reset, shared with the FIFO.
- req  in  num_req  per-producer request; held high while the producer has a word presented.
- req_data  in  num_req*word_width  flattened producer words; producer i occupies bits [i*word_width +: word_width].
- req_last  in  num_req  marks the presented word as the last of the producer's packet.
- full  in  1  FIFO full flag (w_clk domain).
- wr  out  1  FIFO write enable.
- data_in  out  word_width  FIFO write data.
- grant  out  num_req  one-hot registered grant; all-zero when idle.
- ack  out  num_req  one-hot; word of the granted producer consumed this cycle.
- busy  out  1  high while in XFER.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, grant=0, burst count=0.
  - Round-robin pointer = num_req-1, so producer 0 has first priority.
  - wr=0, ack=0, busy=0, data_in=0.
  - Reset mid-burst aborts the burst immediately with no write. Words not yet acked remain owned by their producer.
- States: IDLE, XFER.
- IDLE:
  - If any req is high, select the first requester searching upward from pointer+1 (mod num_req).
  - At the next edge: grant=onehot(sel), count=0, state=XFER.
  - If no req, stay in IDLE. Arbitration is not blocked by full.
- XFER, granted index g:
  - wr = req[g] & ~full, combinational from registered grant.
  - ack[g] = wr.
  - data_in = req_data[g], muxed by grant; 0 when grant=0.
  - On each write, count increments at the edge.
  - Exit to IDLE at the edge when any of these holds:
    - (a) wr & req_last[g];
    - (b) wr & count==max_burst-1;
    - (c) req[g]==0 (producer withdrew, no write this cycle).
  - On exit: pointer=g, grant=0, count=0.
  - Simultaneous (a) and (b) produce a single exit.
- full=1 in XFER: wr=0, ack=0, count and grant held. Any number of stall cycles are allowed, and the burst resumes the cycle full drops.
- Latency:
  - Request seen in IDLE at edge k → grant visible after edge k.
  - First write occurs in cycle k+1 if not full.
  - One IDLE cycle always separates consecutive grants (re-arbitration bubble).
- Throughput: up to 1 word/cycle within a burst; max_burst words per max_burst+1 cycles under saturation.
- Invariants:
  - grant is one-hot or zero.
  - wr implies exactly one ack bit high, and that bit equals grant.
  - The FIFO is never written while full=1.
- Count width: clog2(max_burst)+1 bits; no wrap beyond max_burst-1.

Test Plan:
- Reset then single producer: req=4'b0010, req_data[1]=104, 105, 95, 116, last on 116, full=0 → grant=4'b0010 one cycle after req; wr high 4 consecutive cycles; FIFO receives 104, 105, 95, 116; back to IDLE; pointer=1.
- All four req high continuously, last never asserted, max_burst=4 → grants in order 0, 1, 2, 3, 0. Each burst is exactly 4 acks, separated by one idle cycle (busy=0).
- Full stall: producer 2 granted, after 2 words force full=1 for 5 cycles → wr=0 and ack=0 throughout. Burst then completes the remaining 2 words; total 4 words, no loss or duplication.
- Withdraw: producer 3 granted, deasserts req after 1 word → exits next edge with count=1. A pending producer 0 is granted next (wrap-around from pointer 3).
- Reset mid-burst: reset_n pulsed low 1 ns during producer 1's second word → grant=0, wr=0 immediately. After release, requests 4'b0011 grant producer 0 first.
- End-to-end with asyn_fifo_top (w_clk 6 ns, r_clk 16 ns):
  - Two producers write "hi" and "_there" (104, 105 / 95, 116, 104, 101, 114, 101) until full.
  - Read side drains to empty.
  - Data out is a per-producer in-order interleaving by burst; no write is issued while full.
